// File: rtl/gb_apu_pkg.sv
// gb_apu_pkg: shared constants and types for the wave channel register file
//   NR30..NR34 addresses, wave RAM base, readback OR-masks, wave array type.
package gb_apu_pkg;
    localparam logic [7:0] NR30_ADDR  = 8'h1A;
    localparam logic [7:0] NR31_ADDR  = 8'h1B;
    localparam logic [7:0] NR32_ADDR  = 8'h1C;
    localparam logic [7:0] NR33_ADDR  = 8'h1D;
    localparam logic [7:0] NR34_ADDR  = 8'h1E;
    localparam logic [7:0] WAVE_BASE  = 8'h30;
    localparam logic [7:0] NR30_RMASK = 8'h7F;
    localparam logic [7:0] NR31_RMASK = 8'hFF;
    localparam logic [7:0] NR32_RMASK = 8'h9F;
    localparam logic [7:0] NR33_RMASK = 8'hFF;
    localparam logic [7:0] NR34_RMASK = 8'hBF;
    typedef logic [15:0][7:0] wave_t;
endpackage

// File: rtl/gb_wave_ram.sv
// gb_wave_ram: 16x8 wave storage, async reset, one write port, CPU and channel read ports
//   clk, reset       : clock, async active-high reset (all bytes -> RESET_WAVE)
//   we, waddr, wdata : CPU write port
//   raddr, rdata     : CPU read port (combinational, pre-write value)
//   ch_addr, ch_data : channel read port (combinational)
module gb_wave_ram
    import gb_apu_pkg::*;
#(
    parameter logic [7:0] RESET_WAVE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata,
    input  logic [3:0] ch_addr,
    output logic [7:0] ch_data
);
    wave_t ram_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ram_q <= {16{RESET_WAVE}};
        else if (we) ram_q[waddr] <= wdata;
    end
    assign rdata   = ram_q[raddr];
    assign ch_data = ram_q[ch_addr];
endmodule

// File: rtl/gb_wave_regs.sv
// gb_wave_regs: NR30-NR34 register file and wave RAM front end for the wave channel
//   Optional macro WAVE_LOCK_EN: while enable=1, CPU wave RAM accesses use wave_addr.
//   clk, reset          : clock, async active-high reset
//   apu_on              : NR52 power; 0 holds channel registers cleared
//   cpu_addr/wdata/wr/rd: CPU bus (low byte of FFxx), cpu_rdata registered read data
//   enable, wave_addr   : channel feedback and wave byte lookup, wave_data combinational
//   on, length, volume, frequency, single, start : channel controls
module gb_wave_regs
    import gb_apu_pkg::*;
#(
    parameter logic [7:0] RESET_WAVE = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        apu_on,
    input  logic [7:0]  cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic [7:0]  cpu_rdata,
    input  logic        enable,
    input  logic [3:0]  wave_addr,
    output logic [7:0]  wave_data,
    output logic        on,
    output logic [7:0]  length,
    output logic [1:0]  volume,
    output logic [10:0] frequency,
    output logic        single,
    output logic        start
);
    logic        on_q, single_q, start_q;
    logic [7:0]  length_q, rdata_q, ram_rdata;
    logic [1:0]  volume_q;
    logic [10:0] freq_q;
    logic [3:0]  ram_idx;
    logic [7:0]  rd_d;
    logic        is_wave;

    assign is_wave = cpu_addr[7:4] == WAVE_BASE[7:4];
`ifdef WAVE_LOCK_EN
    assign ram_idx = enable ? wave_addr : cpu_addr[3:0];
`else
    logic unused_enable;
    assign unused_enable = enable;
    assign ram_idx = cpu_addr[3:0];
`endif

    gb_wave_ram #(.RESET_WAVE(RESET_WAVE)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (cpu_wr && is_wave),
        .waddr   (ram_idx),
        .wdata   (cpu_wdata),
        .raddr   (ram_idx),
        .rdata   (ram_rdata),
        .ch_addr (wave_addr),
        .ch_data (wave_data)
    );

    // Fields are gated by apu_on so a read in the cycle power drops already sees zeros.
    always_comb begin
        rd_d = is_wave                ? ram_rdata
             : cpu_addr == NR30_ADDR  ? ({on_q & apu_on, 7'h00} | NR30_RMASK)
             : cpu_addr == NR32_ADDR  ? ({1'b0, volume_q & {2{apu_on}}, 5'h00} | NR32_RMASK)
             : cpu_addr == NR34_ADDR  ? ({1'b0, single_q & apu_on, 6'h00} | NR34_RMASK)
             : 8'hFF;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            on_q     <= 1'b0;
            length_q <= 8'h00;
            volume_q <= 2'b00;
            freq_q   <= 11'h000;
            single_q <= 1'b0;
            start_q  <= 1'b0;
            rdata_q  <= 8'h00;
        end else begin
            if (!apu_on) begin
                on_q     <= 1'b0;
                length_q <= 8'h00;
                volume_q <= 2'b00;
                freq_q   <= 11'h000;
                single_q <= 1'b0;
                start_q  <= 1'b0;
            end else begin
                start_q <= cpu_wr && cpu_addr == NR34_ADDR && cpu_wdata[7];
                if (cpu_wr && cpu_addr == NR30_ADDR) on_q <= cpu_wdata[7];
                if (cpu_wr && cpu_addr == NR31_ADDR) length_q <= cpu_wdata;
                if (cpu_wr && cpu_addr == NR32_ADDR) volume_q <= cpu_wdata[6:5];
                if (cpu_wr && cpu_addr == NR33_ADDR) freq_q[7:0] <= cpu_wdata;
                if (cpu_wr && cpu_addr == NR34_ADDR) begin
                    freq_q[10:8] <= cpu_wdata[2:0];
                    single_q     <= cpu_wdata[6];
                end
            end
            if (cpu_rd) rdata_q <= rd_d;
        end
    end

    assign on        = on_q;
    assign length    = length_q;
    assign volume    = volume_q;
    assign frequency = freq_q;
    assign single    = single_q;
    assign start     = start_q;
    assign cpu_rdata = rdata_q;
endmodule

// File: tb/tb_gb_wave_regs.sv
// tb_gb_wave_regs: randomized self-checking bench for gb_wave_regs against a behavioural model
module tb_gb_wave_regs;
    logic        clk = 1'b0, reset = 1'b1, apu_on = 1'b0;
    logic [7:0]  cpu_addr = 8'h00, cpu_wdata = 8'h00, cpu_rdata;
    logic        cpu_wr = 1'b0, cpu_rd = 1'b0, enable = 1'b0;
    logic [3:0]  wave_addr = 4'h0;
    logic [7:0]  wave_data, length;
    logic        on, single, start;
    logic [1:0]  volume;
    logic [10:0] frequency;

    int n_cmp = 0, n_bad = 0;

    logic        m_on, m_single;
    logic [7:0]  m_len;
    logic [1:0]  m_vol;
    logic [10:0] m_freq;
    logic [7:0]  m_wave [16];
    logic [7:0]  exp_rdata;
    logic        exp_start;

    gb_wave_regs dut (
        .clk(clk), .reset(reset), .apu_on(apu_on),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_rdata(cpu_rdata), .enable(enable), .wave_addr(wave_addr), .wave_data(wave_data),
        .on(on), .length(length), .volume(volume), .frequency(frequency),
        .single(single), .start(start)
    );

    always #5 clk = ~clk;

    function automatic int widx(input logic [7:0] a);
`ifdef WAVE_LOCK_EN
        return enable ? int'(wave_addr) : int'(a[3:0]);
`else
        return int'(a[3:0]);
`endif
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        logic o = apu_on ? m_on : 1'b0;
        logic s = apu_on ? m_single : 1'b0;
        logic [1:0] v = apu_on ? m_vol : 2'b00;
        if (a >= 8'h30 && a <= 8'h3F) return m_wave[widx(a)];
        case (a)
            8'h1A: return {o, 7'h7F};
            8'h1C: return {1'b1, v, 5'h1F};
            8'h1E: return {1'b1, s, 6'h3F};
            default: return 8'hFF;
        endcase
    endfunction

    // One bus cycle: model is advanced from the pre-edge state, then the DUT is clocked.
    task automatic step(input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] d);
        exp_start = apu_on && wr && a == 8'h1E && d[7];
        if (rd) exp_rdata = model_read(a);
        if (wr && a[7:4] == 4'h3) m_wave[widx(a)] = d;
        if (!apu_on) begin
            m_on = 0; m_len = 0; m_vol = 0; m_freq = 0; m_single = 0;
        end else if (wr) begin
            case (a)
                8'h1A: m_on = d[7];
                8'h1B: m_len = d;
                8'h1C: m_vol = d[6:5];
                8'h1D: m_freq[7:0] = d;
                8'h1E: begin m_freq[10:8] = d[2:0]; m_single = d[6]; end
                default: ;
            endcase
        end
        cpu_wr = wr; cpu_rd = rd; cpu_addr = a; cpu_wdata = d;
        @(posedge clk); #1;
        cpu_wr = 0; cpu_rd = 0;
    endtask

    task automatic test_reset;
        m_on = 0; m_len = 0; m_vol = 0; m_freq = 0; m_single = 0; exp_rdata = 0; exp_start = 0;
        for (int i = 0; i < 16; i++) m_wave[i] = 8'h00;
        reset = 1; repeat (3) @(posedge clk); #1;
        n_cmp++;
        if ({on, length, volume, frequency, single, start, cpu_rdata} !== 32'h0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", {on, length, volume, frequency, single, start, cpu_rdata});
        end
        reset = 0; @(posedge clk); #1;
        begin
            logic [7:0] a_l [6] = '{8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h30};
            logic [7:0] e_l [6] = '{8'h7F, 8'hFF, 8'h9F, 8'hFF, 8'hBF, 8'h00};
            for (int i = 0; i < 6; i++) begin
                step(0, 1, a_l[i], 8'h00);
                n_cmp++;
                if (cpu_rdata !== e_l[i]) begin
                    n_bad++; $display("FAIL reset_read_%h: got %h want %h", a_l[i], cpu_rdata, e_l[i]);
                end
            end
        end
    endtask

    task automatic test_freq_start;
        apu_on = 1;
        step(1, 0, 8'h1D, 8'hF8);
        step(1, 0, 8'h1E, 8'h87);
        n_cmp++;
        if ({frequency, single, start} !== {11'h7F8, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL trigger: freq %h single %b start %b want 7f8 0 1", frequency, single, start);
        end
        step(0, 0, 8'h00, 8'h00);
        n_cmp++;
        if (start !== 1'b0) begin
            n_bad++; $display("FAIL start_one_cycle: got %b want 0", start);
        end
    endtask

    task automatic test_vol_on;
        step(1, 0, 8'h1C, 8'h60);
        step(0, 1, 8'h1C, 8'h00);
        n_cmp++;
        if ({volume, cpu_rdata} !== {2'b11, 8'hFF}) begin
            n_bad++; $display("FAIL nr32: vol %b rd %h want 11 ff", volume, cpu_rdata);
        end
        step(1, 0, 8'h1A, 8'h80);
        step(1, 1, 8'h1A, 8'h00);
        n_cmp++;
        if ({on, cpu_rdata} !== {1'b0, 8'hFF}) begin
            n_bad++; $display("FAIL nr30_rw_same: on %b rd %h want 0 ff", on, cpu_rdata);
        end
        step(0, 1, 8'h1A, 8'h00);
        n_cmp++;
        if (cpu_rdata !== 8'h7F) begin
            n_bad++; $display("FAIL nr30_off: rd %h want 7f", cpu_rdata);
        end
    endtask

    task automatic test_wave;
        for (int i = 0; i < 16; i++) step(1, 0, 8'h30 + 8'(i), 8'hF0 + 8'(i));
        for (int i = 0; i < 16; i++) begin
            wave_addr = 4'(i); #1;
            n_cmp++;
            if (wave_data !== 8'hF0 + 8'(i)) begin
                n_bad++; $display("FAIL wave_sweep_%0d: got %h want %h", i, wave_data, 8'hF0 + 8'(i));
            end
        end
        step(0, 1, 8'h35, 8'h00);
        n_cmp++;
        if (cpu_rdata !== 8'hF5) begin
            n_bad++; $display("FAIL wave_read_35: got %h want f5", cpu_rdata);
        end
        wave_addr = 4'h7;
        step(1, 1, 8'h37, 8'h42);
        n_cmp++;
        if ({cpu_rdata, wave_data} !== {8'hF7, 8'h42}) begin
            n_bad++; $display("FAIL wave_rw_same: rd %h data %h want f7 42", cpu_rdata, wave_data);
        end
    endtask

    task automatic test_back_to_back;
        step(1, 0, 8'h1E, 8'h80);
        n_cmp++;
        if (start !== 1'b1) begin
            n_bad++; $display("FAIL b2b_first: start %b want 1", start);
        end
        step(1, 0, 8'h1E, 8'hC1);
        n_cmp++;
        if ({start, single} !== 2'b11) begin
            n_bad++; $display("FAIL b2b_second: start,single %b want 11", {start, single});
        end
        step(1, 0, 8'h1E, 8'h41);
        n_cmp++;
        if (start !== 1'b0) begin
            n_bad++; $display("FAIL b2b_notrig: start %b want 0", start);
        end
    endtask

    task automatic test_apu_off;
        step(1, 0, 8'h1B, 8'h3C);
        step(1, 0, 8'h1A, 8'h80);
        apu_on = 0;
        step(0, 1, 8'h1C, 8'h00);
        n_cmp++;
        if ({on, length, volume, frequency, single, start, cpu_rdata} !== {24'h0, 8'h9F}) begin
            n_bad++; $display("FAIL apu_off_clear: got %h want 9f", {on, length, volume, frequency, single, start, cpu_rdata});
        end
        step(1, 0, 8'h1E, 8'h80);
        n_cmp++;
        if ({start, frequency} !== 12'h0) begin
            n_bad++; $display("FAIL apu_off_trig: start %b freq %h want 0 0", start, frequency);
        end
        step(0, 1, 8'h33, 8'h00);
        n_cmp++;
        if (cpu_rdata !== 8'hF3) begin
            n_bad++; $display("FAIL apu_off_wave: got %h want f3", cpu_rdata);
        end
        step(1, 0, 8'h3E, 8'h77);
        wave_addr = 4'hE; #1;
        n_cmp++;
        if (wave_data !== 8'h77) begin
            n_bad++; $display("FAIL apu_off_wave_wr: got %h want 77", wave_data);
        end
        apu_on = 1;
    endtask

    task automatic test_wave_lock;
        logic [7:0] b3, b10;
        enable = 1; wave_addr = 4'h3;
        step(1, 0, 8'h3A, 8'h5A);
        step(0, 1, 8'h30, 8'h00);
        n_cmp++;
        if (cpu_rdata !== exp_rdata) begin
            n_bad++; $display("FAIL lock_read_30: got %h want %h", cpu_rdata, exp_rdata);
        end
        enable = 0;
        wave_addr = 4'h3;  #1; b3 = wave_data;
        wave_addr = 4'hA;  #1; b10 = wave_data;
`ifdef WAVE_LOCK_EN
        n_cmp++;
        if ({b3, b10} !== {8'h5A, 8'hFA}) begin
            n_bad++; $display("FAIL lock_bytes: b3 %h b10 %h want 5a fa", b3, b10);
        end
`else
        n_cmp++;
        if ({b3, b10} !== {8'hF3, 8'h5A}) begin
            n_bad++; $display("FAIL nolock_bytes: b3 %h b10 %h want f3 5a", b3, b10);
        end
`endif
    endtask

    task automatic test_random;
        logic [7:0] a, d;
        logic wr, rd;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) apu_on = ~apu_on;
            enable = 1'($urandom);
            wave_addr = 4'($urandom);
            case ($urandom_range(0, 3))
                0: a = 8'h1A + 8'($urandom_range(0, 4));
                1, 2: a = 8'h30 + 8'($urandom_range(0, 15));
                default: a = 8'($urandom);
            endcase
            d = 8'($urandom);
            wr = 1'($urandom);
            rd = 1'($urandom);
            step(wr, rd, a, d);
            n_cmp++;
            if ({on, length, volume, frequency, single, start, cpu_rdata, wave_data} !==
                {m_on, m_len, m_vol, m_freq, m_single, exp_start, exp_rdata, m_wave[wave_addr]}) begin
                n_bad++;
                $display("FAIL random_%0d: got %h want %h", n,
                    {on, length, volume, frequency, single, start, cpu_rdata, wave_data},
                    {m_on, m_len, m_vol, m_freq, m_single, exp_start, exp_rdata, m_wave[wave_addr]});
            end
        end
    endtask

    initial begin
        test_reset;
        test_freq_start;
        test_vol_on;
        test_wave;
        test_back_to_back;
        test_apu_off;
        test_wave_lock;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
